// File: rtl/riscv_muldiv.sv
// Iterative radix-2 multiply/divide unit covering the full RISC-V M-extension.
// Operands are reduced to unsigned magnitudes; the sign is re-applied in one FIX cycle.
module riscv_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int W2 = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [2:0]        funct3_r;
  logic              neg_r;
  logic [CW-1:0]     cnt_r;
  logic [DATA_W-1:0] addend_r;
  logic [W2-1:0]     prod_r;
  logic [DATA_W-1:0] result_r;
  logic              busy_r, done_r;

  logic              is_div_s, sa_s, sb_s, neg_s, div_zero_s, div_ovf_s;
  logic [DATA_W-1:0] a_mag_s, b_mag_s, special_res_s;
  logic [DATA_W:0]   add_s, shifted_s, diff_s;
  logic [W2-1:0]     mul_step_s, div_step_s;
  logic [DATA_W-1:0] hi_s, lo_s, hi_neg_s, fix_res_s;

  assign is_div_s = funct3[2];
  assign sa_s  = op_a[DATA_W-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                   (funct3 == 3'b100) | (funct3 == 3'b110));
  assign sb_s  = op_b[DATA_W-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                   (funct3 == 3'b110));
  // Remainder follows the dividend only; everything else follows the sign product.
  assign neg_s   = (funct3 == 3'b110) ? sa_s : (sa_s ^ sb_s);
  assign a_mag_s = sa_s ? (ZERO - op_a) : op_a;
  assign b_mag_s = sb_s ? (ZERO - op_b) : op_b;

  assign div_zero_s    = is_div_s & (op_b == ZERO);
  assign div_ovf_s     = is_div_s & ~funct3[0] & (op_a == MOST_NEG) & (op_b == ONES);
  assign special_res_s = div_zero_s ? (funct3[1] ? op_a : ONES) : (funct3[1] ? ZERO : op_a);

  // Multiply: product high half accumulates, multiplier shifts out of the low half.
  assign add_s      = {1'b0, prod_r[W2-1:DATA_W]} + (prod_r[0] ? {1'b0, addend_r} : {1'b0, ZERO});
  assign mul_step_s = {add_s, prod_r[DATA_W-1:1]};
  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign shifted_s  = prod_r[W2-1:DATA_W-1];
  assign diff_s     = shifted_s - {1'b0, addend_r};
  assign div_step_s = diff_s[DATA_W] ? {shifted_s[DATA_W-1:0], prod_r[DATA_W-2:0], 1'b0}
                                     : {diff_s[DATA_W-1:0], prod_r[DATA_W-2:0], 1'b1};

  assign hi_s     = prod_r[W2-1:DATA_W];
  assign lo_s     = prod_r[DATA_W-1:0];
  // High word of the negated product: borrow from the low half only when it is zero.
  assign hi_neg_s = (lo_s == ZERO) ? (ZERO - hi_s) : ~hi_s;

  // Output word selection and sign correction for the FIX cycle.
  always_comb begin
    fix_res_s = lo_s;
    case (funct3_r)
      3'b000:                 fix_res_s = lo_s;
      3'b001, 3'b010, 3'b011: fix_res_s = neg_r ? hi_neg_s : hi_s;
      3'b100, 3'b101:         fix_res_s = neg_r ? (ZERO - lo_s) : lo_s;
      default:                fix_res_s = neg_r ? (ZERO - hi_s) : hi_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start & ~flush) begin
          next_state_s = (div_zero_s | div_ovf_s) ? DONE : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          next_state_s = IDLE;
        end else if (cnt_r == CW'(DATA_W - 1)) begin
          next_state_s = FIX;
        end else begin
          next_state_s = CALC;
        end
      end
      FIX:     next_state_s = flush ? IDLE : DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_r <= 3'b000;
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      addend_r <= ZERO;
      prod_r   <= {W2{1'b0}};
      result_r <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start & ~flush) begin
            funct3_r <= funct3;
            neg_r    <= neg_s;
            cnt_r    <= {CW{1'b0}};
            addend_r <= is_div_s ? b_mag_s : a_mag_s;
            prod_r   <= {ZERO, (is_div_s ? a_mag_s : b_mag_s)};
            if (div_zero_s | div_ovf_s) begin
              result_r <= special_res_s;
            end else begin
              result_r <= result_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          cnt_r  <= cnt_r + CW'(1'b1);
          prod_r <= funct3_r[2] ? div_step_s : mul_step_s;
        end
        FIX: begin
          if (!flush) begin
            result_r <= fix_res_s;
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: directed 32-bit vectors plus an 8/16-bit sweep
// against an arithmetic reference model; a single monitor performs every comparison.
module tb_riscv_muldiv;
  typedef struct { logic [31:0] res; int t0; int lat; } exp_t;
  typedef struct { int lane; logic busy; logic [31:0] res; } probe_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v  [3];
  logic [2:0]  funct3_v [3];
  logic [31:0] a_v      [3];
  logic [31:0] b_v      [3];
  logic        flush_v  [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic [31:0] result_v [3];

  exp_t   exp_q [3][$];
  probe_t probe_q [$];
  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane 0 is 32 bits wide, lane 1 is 16, lane 2 is 8.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int W = (g == 0) ? 32 : ((g == 1) ? 16 : 8);
    logic [W-1:0] res_w;
    riscv_muldiv #(.DATA_W(W)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start_v[g]),
      .funct3 (funct3_v[g]),
      .op_a   (a_v[g][W-1:0]),
      .op_b   (b_v[g][W-1:0]),
      .flush  (flush_v[g]),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .result (res_w)
    );
    assign result_v[g] = 32'(res_w);
  end

  function automatic int lane_w(int l);
    return (l == 0) ? 32 : ((l == 1) ? 16 : 8);
  endfunction

  function automatic logic [31:0] ref_op(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub, sa, sb, r;
    mask = (64'sd1 <<< w) - 64'sd1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[w-1] ? ua - (64'sd1 <<< w) : ua;
    sb = b[w-1] ? ub - (64'sd1 <<< w) : ub;
    case (f)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> w;
      3'd2:    r = (sa * ub) >>> w;
      3'd3:    r = (ua * ub) >>> w;
      3'd4:    r = (ub == 64'sd0) ? mask : sa / sb;
      3'd5:    r = (ub == 64'sd0) ? mask : ua / ub;
      3'd6:    r = (ub == 64'sd0) ? ua : sa % sb;
      default: r = (ub == 64'sd0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consume expected results on every done, then any pending state probes.
  always @(negedge clk) begin : monitor
    exp_t   e;
    probe_t p;
    for (int l = 0; l < 3; l++) begin
      if (done_v[l]) begin
        if (exp_q[l].size() == 0) begin
          check($sformatf("unexpected_done_l%0d", l), 32'd1, 32'd0);
        end else begin
          e = exp_q[l].pop_front();
          check($sformatf("result_l%0d", l), result_v[l], e.res);
          check($sformatf("latency_l%0d", l), 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      check($sformatf("busy_l%0d", p.lane), 32'(busy_v[p.lane]), 32'(p.busy));
      check($sformatf("done_l%0d", p.lane), 32'(done_v[p.lane]), 32'd0);
      check($sformatf("held_result_l%0d", p.lane), result_v[p.lane], p.res);
      check($sformatf("pending_l%0d", p.lane), 32'(exp_q[p.lane].size()), 32'd0);
    end
  end

  task automatic probe(int l, logic bsy, logic [31:0] res);
    probe_t p;
    p.lane = l; p.busy = bsy; p.res = res;
    probe_q.push_back(p);
  endtask

  task automatic pulse(int l, logic [2:0] f, logic [31:0] a, logic [31:0] b, logic fl, output int t0);
    @(posedge clk); #1;
    t0 = cyc;
    start_v[l] = 1'b1; funct3_v[l] = f; a_v[l] = a; b_v[l] = b; flush_v[l] = fl;
    @(posedge clk); #1;
    start_v[l] = 1'b0; flush_v[l] = 1'b0;
  endtask

  task automatic wait_idle(int l);
    int k;
    k = 0;
    while (k < 200 && (exp_q[l].size() != 0 || busy_v[l])) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) probe(l, 1'b0, 32'd0);
  endtask

  task automatic issue(int l, logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] res, int lat);
    exp_t e;
    int   t0;
    pulse(l, f, a, b, 1'b0, t0);
    e.res = res; e.t0 = t0; e.lat = lat;
    exp_q[l].push_back(e);
    wait_idle(l);
  endtask

  initial begin : stim
    int          t0, w, lat;
    logic [31:0] a, b, m, ex;
    logic [2:0]  f;
    logic        special;
    reset = 1'b1;
    for (int l = 0; l < 3; l++) begin
      start_v[l] = 1'b0; funct3_v[l] = 3'b000; a_v[l] = 32'd0; b_v[l] = 32'd0; flush_v[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int l = 0; l < 3; l++) probe(l, 1'b0, 32'd0);

    // Multiply and divide, 32 bits
    issue(0, 3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    issue(0, 3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34);
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34);
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34);
    issue(0, 3'b101, 32'd100,        32'd7,          32'd14,        34);
    issue(0, 3'b111, 32'd100,        32'd7,          32'd2,         34);
    // Special-case divides complete in one cycle
    issue(0, 3'b101, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1);
    issue(0, 3'b110, 32'h0000_1234, 32'd0,          32'h0000_1234, 1);
    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    issue(0, 3'b010, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 34);

    // A start while busy is ignored
    pulse(0, 3'b101, 32'd100, 32'd7, 1'b0, t0);
    exp_q[0].push_back('{res: 32'd14, t0: t0, lat: 34});
    repeat (3) @(posedge clk);
    pulse(0, 3'b000, 32'd3, 32'd3, 1'b0, t0);
    wait_idle(0);
    probe(0, 1'b0, 32'd14);

    // Flush mid-CALC: no done, result retained
    pulse(0, 3'b000, 32'd5, 32'd5, 1'b0, t0);
    repeat (9) @(posedge clk);
    #1 flush_v[0] = 1'b1;
    @(posedge clk); #1 flush_v[0] = 1'b0;
    probe(0, 1'b0, 32'd14);
    repeat (40) @(posedge clk);
    probe(0, 1'b0, 32'd14);

    // Flush together with start in IDLE: start dropped
    pulse(0, 3'b101, 32'd9, 32'd0, 1'b1, t0);
    @(posedge clk); #1;
    probe(0, 1'b0, 32'd14);

    // Reset mid-CALC clears everything, no late done
    pulse(0, 3'b011, 32'd11, 32'd13, 1'b0, t0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    probe(0, 1'b0, 32'd0);
    repeat (45) @(posedge clk);
    probe(0, 1'b0, 32'd0);

    // Width sweep on the 16- and 8-bit lanes
    for (int l = 1; l < 3; l++) begin
      w = lane_w(l);
      m = (32'd1 << w) - 32'd1;
      for (int i = 0; i < 24; i++) begin
        f = 3'(i % 8);
        a = $urandom & m;
        b = $urandom & m;
        if (i >= 8 && i < 16) b = 32'd0;
        if (i >= 16) begin
          a = 32'd1 << (w - 1);
          b = m;
        end
        ex = ref_op(w, f, a, b);
        special = f[2] && (b == 32'd0 || (!f[0] && a == (32'd1 << (w - 1)) && b == m));
        lat = special ? 1 : w + 2;
        issue(l, f, a, b, ex, lat);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Parametrised iterative multiply/divide execute unit for the pipelined RISC-V core. It implements the full M-extension operation set at a configurable data width. It sits beside the ALU in the EX stage and stalls the pipeline through `busy` while an operation runs. `start`/`done` handshake with the hazard logic; `flush` supports branch/jump squash.

## Interface
- `DATA_W`, 32, operand/result width (even, ≥ 8)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; clears all state
- `start`  in  1  request; accepted only while `busy`=0
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  DATA_W  rs1 operand (multiplicand / dividend)
- `op_b`  in  DATA_W  rs2 operand (multiplier / divisor)
- `flush`  in  1  abort in-flight op; no `done` produced
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse; `result` valid in that cycle
- `result`  out  DATA_W  last completed result; held until next `done`

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on `start`, latch `funct3`, operand magnitudes and sign flags; clear iteration counter.
  - DIV/REM/DIVU/REMU special cases bypass CALC → DONE:
    - divisor 0: quotient all-ones, remainder = `op_a`.
    - signed overflow (`op_a` = most negative, `op_b` = all-ones): quotient = `op_a`, remainder 0.
  - Otherwise → CALC.
- CALC: one radix-2 step per cycle for exactly DATA_W cycles.
  - Multiply: shift-add of magnitudes into a 2·DATA_W product register.
  - Divide: restoring division of magnitudes; quotient and remainder registers.
  - Counter reaches DATA_W−1 → FIX.
- FIX: apply sign correction, select output word, load `result` → DONE.
  - MUL: low DATA_W bits; any sign combination.
  - MULH: high bits, signed × signed.
  - MULHSU: high bits, signed `op_a` × unsigned `op_b`.
  - MULHU: high bits, unsigned × unsigned.
  - DIV: quotient negated iff operand signs differ.
  - REM: remainder takes sign of dividend.
  - Unsigned ops: no correction.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` while `busy`=1, including the DONE cycle, is ignored. Inputs are not re-sampled.
- `flush`:
  - Any non-IDLE state → IDLE next cycle; `done` suppressed; `result` unchanged.
  - `flush` and `start` together in IDLE: start ignored.
- Widths: internal product 2·DATA_W bits; magnitudes DATA_W bits, unsigned. Most-negative operand magnitude is represented correctly as 2^(DATA_W−1).

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0; counter and internal registers 0.
- `reset` overrides `flush` and `start` in the same cycle. Reset mid-operation returns to IDLE with no `done`.
- `start` sampled at edge T (IDLE).
- Normal op:
  - CALC occupies cycles T+1 … T+DATA_W.
  - FIX occupies T+DATA_W+1.
  - `done`=1 in T+DATA_W+2. Latency DATA_W+2; 34 at DATA_W=32.
- Special-case divide: DONE in cycle T+1, `done`=1 at T+1, latency 1.
- `busy` rises at T+1 and falls the cycle after `done`. Next `start` is accepted no earlier than the cycle after `done`.
- Throughput: one op per DATA_W+3 cycles.
- `result` changes only on the FIX→DONE edge or the special-case IDLE→DONE edge.

## Test plan
- Reset: assert `reset` 2 cycles mid-CALC → `busy`=0, `done`=0, `result`=0, no later `done`.
- Multiply, DATA_W=32:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; `done` exactly 34 cycles after start.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- Special cases:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF, and REM 0x1234 / 0 → 0x1234, each with `done` at T+1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Handshake:
  - `start` with new operands at T+5 while busy → ignored; original result delivered.
  - `flush` at T+10 → IDLE at T+11, no `done`, `result` retains previous value.
- Width sweep: DATA_W=8 and 16, randomized operands over all 8 funct3 codes vs. reference model; latency DATA_W+2 checked on every op.
